// File: rtl/rect_rasterizer.sv
// Rectangle rasterizer: walks a screen-clipped rectangle row-major
// and emits one frame-buffer pixel write per covered pixel.
module rect_rasterizer #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int COORD_W  = 10,
  parameter int COLOR_W  = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [31:0]        rect_x1,
  input  logic [31:0]        rect_y1,
  input  logic [31:0]        rect_x2,
  input  logic [31:0]        rect_y2,
  input  logic [COLOR_W-1:0] rect_color,
  input  logic               rect_valid,
  output logic               rect_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_we,
  input  logic               pix_stall,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW,
    DONE
  } state_t;

  state_t state;

  logic [31:0] x1Full;
  logic [31:0] y1Full;
  logic [31:0] xEnd;
  logic [31:0] yEnd;
  logic [31:0] x2Clip;
  logic [31:0] y2Clip;

  logic [COORD_W-1:0] xStart;
  logic [COORD_W-1:0] xLast;
  logic [COORD_W-1:0] yLast;

  logic isEmpty;
  logic lastCol;
  logic lastRow;

  assign x2Clip = (rect_x2 < 32'(SCREEN_W)) ? rect_x2 : 32'(SCREEN_W);
  assign y2Clip = (rect_y2 < 32'(SCREEN_H)) ? rect_y2 : 32'(SCREEN_H);

  // Full-width test so off-screen corners never alias after truncation.
  assign isEmpty = (x1Full >= xEnd) || (y1Full >= yEnd);

  assign lastCol = (pix_x == xLast);
  assign lastRow = (pix_y == yLast);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      rect_ready <= 1'b1;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_color  <= '0;
      pix_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      x1Full     <= '0;
      y1Full     <= '0;
      xEnd       <= '0;
      yEnd       <= '0;
      xStart     <= '0;
      xLast      <= '0;
      yLast      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rect_valid) begin
            x1Full     <= rect_x1;
            y1Full     <= rect_y1;
            xEnd       <= x2Clip;
            yEnd       <= y2Clip;
            pix_color  <= rect_color;
            rect_ready <= 1'b0;
            busy       <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (isEmpty) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            pix_x  <= COORD_W'(x1Full);
            pix_y  <= COORD_W'(y1Full);
            xStart <= COORD_W'(x1Full);
            xLast  <= COORD_W'(xEnd - 32'd1);
            yLast  <= COORD_W'(yEnd - 32'd1);
            pix_we <= 1'b1;
            state  <= DRAW;
          end
        end
        DRAW: begin
          if (!pix_stall) begin
            if (lastCol && lastRow) begin
              pix_we <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else if (lastCol) begin
              pix_x <= xStart;
              pix_y <= pix_y + COORD_W'(1);
            end else begin
              pix_x <= pix_x + COORD_W'(1);
            end
          end
        end
        DONE: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          rect_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_rasterizer.sv
// Self-checking bench for rect_rasterizer: directed and random
// rectangles against a nested-loop pixel model.
`timescale 1ns/1ps
module tb_rect_rasterizer;

  logic        clock;
  logic        resetn;
  logic [31:0] rect_x1;
  logic [31:0] rect_y1;
  logic [31:0] rect_x2;
  logic [31:0] rect_y2;
  logic [2:0]  rect_color;
  logic        rect_valid;
  logic        rect_ready;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [2:0]  pix_color;
  logic        pix_we;
  logic        pix_stall;
  logic        busy;
  logic        done;

  rect_rasterizer #(
    .SCREEN_W(640),
    .SCREEN_H(480),
    .COORD_W (10),
    .COLOR_W (3)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .rect_x1   (rect_x1),
    .rect_y1   (rect_y1),
    .rect_x2   (rect_x2),
    .rect_y2   (rect_y2),
    .rect_color(rect_color),
    .rect_valid(rect_valid),
    .rect_ready(rect_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .pix_we    (pix_we),
    .pix_stall (pix_stall),
    .busy      (busy),
    .done      (done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stallMode = 0;
  int doneCount = 0;

  int gotX[$];
  int gotY[$];
  int gotC[$];
  int gotTag[$];
  int gotCyc[$];
  int doneCycQ[$];
  int acceptCycQ[$];

  logic        prevStallWe = 1'b0;
  logic        prevDone = 1'b0;
  logic [22:0] prevVal = '0;

  task automatic checkVal(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    pix_stall = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (stallMode)
        1:       pix_stall = (cyc % 3 == 0);
        2:       pix_stall = ($urandom_range(0, 3) == 0);
        default: pix_stall = 1'b0;
      endcase
    end
  end

  // Log consumed pixels, done pulses and accepts; check stall hold.
  initial forever begin
    @(negedge clock);
    if (!resetn) begin
      prevStallWe = 1'b0;
      prevDone = 1'b0;
    end else begin
      if (prevStallWe && pix_we)
        checkVal("stallHold", {pix_x, pix_y, pix_color}, prevVal);
      if (busy) checkVal("readyWhileBusy", rect_ready, 0);
      if (pix_we && !pix_stall) begin
        gotX.push_back(int'(pix_x));
        gotY.push_back(int'(pix_y));
        gotC.push_back(int'(pix_color));
        gotTag.push_back(doneCount);
        gotCyc.push_back(cyc);
      end
      if (done) begin
        checkVal("donePulse", prevDone, 0);
        checkVal("weAtDone", pix_we, 0);
        doneCycQ.push_back(cyc);
        doneCount++;
      end
      if (rect_valid && rect_ready) acceptCycQ.push_back(cyc + 1);
      prevStallWe = pix_we && pix_stall;
      prevVal = {pix_x, pix_y, pix_color};
      prevDone = done;
    end
  end

  task automatic clearLog();
    gotX.delete();
    gotY.delete();
    gotC.delete();
    gotTag.delete();
    gotCyc.delete();
    doneCycQ.delete();
    acceptCycQ.delete();
    doneCount = 0;
  endtask

  task automatic sendRect(input logic [31:0] x1, input logic [31:0] y1,
                          input logic [31:0] x2, input logic [31:0] y2,
                          input logic [2:0] c);
    int t;
    bit ok;
    t = 0;
    ok = 0;
    @(posedge clock);
    #1;
    rect_x1 = x1;
    rect_y1 = y1;
    rect_x2 = x2;
    rect_y2 = y2;
    rect_color = c;
    rect_valid = 1'b1;
    while (!ok && t < 20000) begin
      @(negedge clock);
      t++;
      if (rect_ready) ok = 1;
    end
    checkVal("acceptSeen", ok, 1);
    @(posedge clock);
    #1;
    rect_valid = 1'b0;
  endtask

  task automatic waitDones(input int n);
    int t;
    t = 0;
    while (doneCount < n && t < 20000) begin
      @(negedge clock);
      t++;
    end
    checkVal("doneSeen", doneCount, n);
    @(negedge clock);
    @(negedge clock);
    checkVal("readyBack", rect_ready, 1);
    checkVal("busyLow", busy, 0);
  endtask

  // Reference: every (x,y) with x1<=x<min(x2,640), y1<=y<min(y2,480).
  task automatic verifyRect(input int k, input logic [31:0] x1,
                            input logic [31:0] y1, input logic [31:0] x2,
                            input logic [31:0] y2, input logic [2:0] c,
                            input bit timing);
    longint xe;
    longint ye;
    int gi[$];
    int n;
    int bad;
    xe = (x2 < 640) ? longint'(x2) : 640;
    ye = (y2 < 480) ? longint'(y2) : 480;
    n = 0;
    bad = 0;
    foreach (gotTag[i]) if (gotTag[i] == k) gi.push_back(i);
    for (longint y = longint'(y1); y < ye; y++) begin
      for (longint x = longint'(x1); x < xe; x++) begin
        if (n < gi.size()) begin
          if (gotX[gi[n]] != x || gotY[gi[n]] != y || gotC[gi[n]] != int'(c))
            bad++;
        end
        n++;
      end
    end
    checkVal($sformatf("count%0d", k), gi.size(), n);
    checkVal($sformatf("order%0d", k), bad, 0);
    if (timing) begin
      if (k < acceptCycQ.size() && k < doneCycQ.size()) begin
        if (n > 0 && gi.size() > 0)
          checkVal($sformatf("firstAt%0d", k), gotCyc[gi[0]],
                   acceptCycQ[k] + 1);
        checkVal($sformatf("doneAt%0d", k), doneCycQ[k],
                 acceptCycQ[k] + 1 + n);
      end else begin
        checkVal($sformatf("logged%0d", k), 0, 1);
      end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int maxX;
    int maxY;
    int t;
    logic [31:0] rx;
    logic [31:0] ry;
    logic [31:0] rw;
    logic [31:0] rh;
    logic [2:0]  rc;

    resetn = 1'b0;
    rect_valid = 1'b0;
    rect_x1 = '0;
    rect_y1 = '0;
    rect_x2 = '0;
    rect_y2 = '0;
    rect_color = '0;
    repeat (3) @(negedge clock);
    checkVal("rstWe", pix_we, 0);
    checkVal("rstBusy", busy, 0);
    checkVal("rstDone", done, 0);
    checkVal("rstPix", {pix_x, pix_y, pix_color}, 0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    checkVal("rstReady", rect_ready, 1);

    // Basic draw, no stall
    clearLog();
    stallMode = 0;
    sendRect(100, 50, 132, 146, 3);
    waitDones(1);
    verifyRect(0, 100, 50, 132, 146, 3, 1);
    checkVal("lastX", gotX[gotX.size()-1], 131);
    checkVal("lastY", gotY[gotY.size()-1], 145);

    // Periodic stall
    clearLog();
    stallMode = 1;
    sendRect(100, 50, 132, 146, 3);
    waitDones(1);
    verifyRect(0, 100, 50, 132, 146, 3, 0);
    stallMode = 0;

    // Clipping at bottom-right
    clearLog();
    sendRect(620, 470, 652, 566, 5);
    waitDones(1);
    verifyRect(0, 620, 470, 652, 566, 5, 1);
    maxX = 0;
    maxY = 0;
    foreach (gotX[i]) begin
      if (gotX[i] > maxX) maxX = gotX[i];
      if (gotY[i] > maxY) maxY = gotY[i];
    end
    checkVal("clipMaxX", maxX, 639);
    checkVal("clipMaxY", maxY, 479);

    // Empty rectangles, incl. corners that alias on-screen if truncated
    clearLog();
    sendRect(200, 200, 200, 232, 1);
    sendRect(700, 10, 732, 42, 2);
    sendRect(1029, 3, 1040, 8, 4);
    sendRect(32'hFFFF_FFF0, 0, 32'hFFFF_FFFF, 4, 6);
    waitDones(4);
    verifyRect(0, 200, 200, 200, 232, 1, 1);
    verifyRect(1, 700, 10, 732, 42, 2, 1);
    verifyRect(2, 1029, 3, 1040, 8, 4, 1);
    verifyRect(3, 32'hFFFF_FFF0, 0, 32'hFFFF_FFFF, 4, 6, 1);

    // Reset in the middle of a draw
    clearLog();
    sendRect(100, 50, 132, 146, 3);
    t = 0;
    while (gotX.size() < 500 && t < 5000) begin
      @(negedge clock);
      t++;
    end
    checkVal("reached500", gotX.size() >= 500, 1);
    resetn = 1'b0;
    #1;
    checkVal("midRstWe", pix_we, 0);
    checkVal("midRstBusy", busy, 0);
    repeat (2) @(negedge clock);
    checkVal("midRstPix", {pix_x, pix_y, pix_color}, 0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    clearLog();
    sendRect(0, 0, 32, 32, 7);
    waitDones(1);
    verifyRect(0, 0, 0, 32, 32, 7, 1);

    // Second request held while the first draws
    clearLog();
    sendRect(100, 50, 132, 146, 3);
    sendRect(10, 20, 18, 25, 6);
    waitDones(2);
    verifyRect(0, 100, 50, 132, 146, 3, 1);
    verifyRect(1, 10, 20, 18, 25, 6, 1);
    if (acceptCycQ.size() >= 2 && doneCycQ.size() >= 1)
      checkVal("b2bAccept", acceptCycQ[1], doneCycQ[0] + 2);
    else
      checkVal("b2bLogged", 0, 1);

    // Random rectangles, alternating stall modes
    for (int i = 0; i < 12; i++) begin
      clearLog();
      stallMode = i % 3;
      rx = $urandom_range(0, 700);
      ry = $urandom_range(0, 520);
      rw = $urandom_range(0, 40);
      rh = $urandom_range(0, 30);
      rc = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) rw = 0;
      sendRect(rx, ry, rx + rw, ry + rh, rc);
      waitDones(1);
      verifyRect(0, rx, ry, rx + rw, ry + rh, rc, stallMode == 0);
    end
    stallMode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
